// File: rtl/data_mem_pkg.sv
// Shared encodings and defaults for the data memory responder and its min scanner.
package data_mem_pkg;

  localparam int unsigned DefaultDepth   = 256;
  localparam int unsigned DefaultLatency = 2;

  typedef enum logic [1:0] {
    AccIdle,
    AccWait,
    AccResp
  } acc_state_e;

  typedef enum logic {
    ScanIdle,
    ScanRun
  } scan_state_e;

endpackage

// File: rtl/data_mem_responder_min_scanner.sv
// Walks a fixed window of the array one word per cycle and reports the signed minimum.
module min_scanner
  import data_mem_pkg::*;
#(
  parameter int unsigned MinBase  = 0,
  parameter int unsigned MinCount = 10,
  parameter int unsigned IdxW     = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [31:0]     word_i,
  output logic [IdxW-1:0] rd_idx_o,
  output logic [31:0]     min_val_o,
  output logic [31:0]     min_idx_o,
  output logic            done_o
);

  scan_state_e     state_q, state_d;
  logic [IdxW-1:0] idx_q;
  logic [31:0]     cnt_q;
  logic [31:0]     best_val_q;
  logic [IdxW-1:0] best_idx_q;
  logic [31:0]     min_val_q;
  logic [IdxW-1:0] min_idx_q;
  logic            done_q;

  logic            last;
  logic            take;
  logic [31:0]     cand_val;
  logic [IdxW-1:0] cand_idx;

  assign last = (cnt_q == 32'(MinCount - 1));
  // Strict less-than so a tie keeps the earlier (lower) index.
  assign take     = (cnt_q == '0) || ($signed(word_i) < $signed(best_val_q));
  assign cand_val = take ? word_i : best_val_q;
  assign cand_idx = take ? idx_q : best_idx_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ScanIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ScanIdle: if (start_i) state_d = ScanRun;
      ScanRun:  if (last) state_d = ScanIdle;
      default:  state_d = ScanIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q      <= '0;
      cnt_q      <= '0;
      best_val_q <= '0;
      best_idx_q <= '0;
      min_val_q  <= '0;
      min_idx_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == ScanIdle) begin
        if (start_i) begin
          idx_q <= IdxW'(MinBase);
          cnt_q <= '0;
        end
      end else begin
        best_val_q <= cand_val;
        best_idx_q <= cand_idx;
        if (last) begin
          min_val_q <= cand_val;
          min_idx_q <= cand_idx;
          done_q    <= 1'b1;
        end else begin
          idx_q <= idx_q + 1'b1;
          cnt_q <= cnt_q + 32'd1;
        end
      end
    end
  end

  always_comb begin
    rd_idx_o  = idx_q;
    min_val_o = min_val_q;
    min_idx_o = 32'(min_idx_q);
    done_o    = done_q;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with fixed-latency single-access handshake and a
// concurrent background min-scanner over a fixed window.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH     = DefaultDepth,
  parameter int unsigned LATENCY   = DefaultLatency,
  parameter int unsigned MIN_BASE  = 0,
  parameter int unsigned MIN_COUNT = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] adr,
  input  logic [31:0] wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  input  logic        scan_start,
  output logic [31:0] min_val,
  output logic [31:0] min_idx,
  output logic        scan_done
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  acc_state_e    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic          wr_q;
  logic          err_q;
  logic [31:0]   mem_q [DEPTH];

  logic          accept;
  logic          bad_req;
  logic [AW-1:0] scan_idx;
  logic [31:0]   scan_word;

  assign accept  = (state_q == AccIdle) && (mem_read || mem_write);
  assign bad_req = (adr[1:0] != 2'b00) || ({2'b00, adr[31:2]} >= 32'(DEPTH))
                || (mem_read && mem_write);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= AccIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      AccIdle: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = AccResp;
            cnt_d   = '0;
          end else begin
            state_d = AccWait;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      AccWait: begin
        if (cnt_q <= 4'd1) begin
          state_d = AccResp;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      AccResp: state_d = AccIdle;
      default: state_d = AccIdle;
    endcase
  end

  always_comb begin
    ready = (state_q == AccResp);
    err   = ready && err_q;
    rdata = (ready && !wr_q && !err_q) ? mem_q[idx_q] : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept) begin
      idx_q   <= adr[AW+1:2];
      wdata_q <= wdata;
      wr_q    <= mem_write;
      err_q   <= bad_req;
    end
  end

  // Writes land on the RESP edge, so the scanner sees them from the next cycle on.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if ((state_q == AccResp) && wr_q && !err_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign scan_word = mem_q[scan_idx];

  min_scanner #(
    .MinBase  (MIN_BASE),
    .MinCount (MIN_COUNT),
    .IdxW     (AW)
  ) u_min_scanner (
    .clk_i     (clk),
    .rst_ni    (rst),
    .start_i   (scan_start),
    .word_i    (scan_word),
    .rd_idx_o  (scan_idx),
    .min_val_o (min_val),
    .min_idx_o (min_idx),
    .done_o    (scan_done)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder at default parameters.
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic [31:0] adr;
  logic [31:0] wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        scan_start;
  logic [31:0] min_val;
  logic [31:0] min_idx;
  logic        scan_done;

  int n_cmp = 0;
  int n_bad = 0;

  data_mem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .adr        (adr),
    .wdata      (wdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .rdata      (rdata),
    .ready      (ready),
    .err        (err),
    .scan_start (scan_start),
    .min_val    (min_val),
    .min_idx    (min_idx),
    .scan_done  (scan_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One access: request in one cycle, accepted on the following edge. lat counts
  // cycles from the accepting cycle to the cycle where ready is seen.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, output logic [31:0] rdat,
                           output logic e, output int lat, output logic rdy_after);
    @(negedge clk);
    mem_read  = rd;
    mem_write = wr;
    adr       = a;
    wdata     = d;
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    lat = 1;
    while (!ready && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rdat = rdata;
    e    = err;
    @(posedge clk);
    #1;
    rdy_after = ready;
  endtask

  logic [31:0] rd_v;
  logic        err_v;
  int          lat_v;
  logic        rdy_v;

  initial begin : main
    logic [31:0] words [10];
    int first_rdy, second_rdy, done_at, done_cnt, n, bad;

    words = '{32'd5, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFD, 32'd9,
              32'd0, 32'd1, 32'd2, 32'd3, 32'd4};
    rst = 1'b0;
    adr = '0;
    wdata = '0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    scan_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", 32'(ready), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_scan_done", 32'(scan_done), 32'd0);
    check_eq("rst_min_val", min_val, 32'd0);
    check_eq("rst_min_idx", min_idx, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Write then read word 2.
    do_access(1'b0, 1'b1, 32'h8, 32'h10, rd_v, err_v, lat_v, rdy_v);
    check_eq("wr8_latency", 32'(lat_v), 32'd2);
    check_eq("wr8_err", 32'(err_v), 32'd0);
    check_eq("wr8_rdata", rd_v, 32'd0);
    check_eq("wr8_ready_one_cycle", 32'(rdy_v), 32'd0);
    do_access(1'b1, 1'b0, 32'h8, 32'h0, rd_v, err_v, lat_v, rdy_v);
    check_eq("rd8_latency", 32'(lat_v), 32'd2);
    check_eq("rd8_rdata", rd_v, 32'h10);
    check_eq("rd8_err", 32'(err_v), 32'd0);
    check_eq("rdata_idle_zero", rdata, 32'd0);

    // Misaligned read, out-of-range write (would alias word 0 if not rejected).
    do_access(1'b1, 1'b0, 32'h6, 32'h0, rd_v, err_v, lat_v, rdy_v);
    check_eq("rd6_err", 32'(err_v), 32'd1);
    check_eq("rd6_rdata", rd_v, 32'd0);
    do_access(1'b0, 1'b1, 32'h400, 32'hDEAD_BEEF, rd_v, err_v, lat_v, rdy_v);
    check_eq("wr400_err", 32'(err_v), 32'd1);
    check_eq("wr400_latency", 32'(lat_v), 32'd2);
    do_access(1'b1, 1'b0, 32'h0, 32'h0, rd_v, err_v, lat_v, rdy_v);
    check_eq("rd0_after_wr400", rd_v, 32'd0);

    // Both request lines high is rejected.
    do_access(1'b0, 1'b1, 32'h4, 32'h1111, rd_v, err_v, lat_v, rdy_v);
    do_access(1'b1, 1'b1, 32'h4, 32'h2222, rd_v, err_v, lat_v, rdy_v);
    check_eq("rdwr4_err", 32'(err_v), 32'd1);
    do_access(1'b1, 1'b0, 32'h4, 32'h0, rd_v, err_v, lat_v, rdy_v);
    check_eq("rd4_unchanged", rd_v, 32'h1111);
    check_eq("rd4_err", 32'(err_v), 32'd0);

    // Request held high: accepted at cycles 1,4,7,... so ready at 2,5,...
    first_rdy = 0;
    second_rdy = 0;
    @(negedge clk);
    mem_read = 1'b1;
    adr = 32'h8;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        if (first_rdy == 0) first_rdy = i;
        else if (second_rdy == 0) second_rdy = i;
      end
    end
    @(negedge clk);
    mem_read = 1'b0;
    repeat (4) @(posedge clk);
    check_eq("hold_first_ready", 32'(first_rdy), 32'd2);
    check_eq("hold_spacing", 32'(second_rdy - first_rdy), 32'd3);

    // Scan of words 0..9.
    for (int i = 0; i < 10; i++) begin
      do_access(1'b0, 1'b1, 32'(i * 4), words[i], rd_v, err_v, lat_v, rdy_v);
    end
    @(negedge clk);
    scan_start = 1'b1;
    @(posedge clk);
    #1;
    scan_start = 1'b0;
    n = 0;
    while (!scan_done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("scan_done_delay", 32'(n), 32'd10);
    check_eq("scan_min_val", min_val, 32'hFFFF_FFFD);
    check_eq("scan_min_idx", min_idx, 32'd1);
    @(posedge clk);
    #1;
    check_eq("scan_done_one_cycle", 32'(scan_done), 32'd0);

    // Most negative value at the last index; second start mid-scan is ignored.
    do_access(1'b0, 1'b1, 32'h24, 32'h8000_0000, rd_v, err_v, lat_v, rdy_v);
    @(negedge clk);
    scan_start = 1'b1;
    @(posedge clk);
    #1;
    scan_start = 1'b0;
    repeat (3) @(negedge clk);
    scan_start = 1'b1;
    @(posedge clk);
    #1;
    scan_start = 1'b0;
    done_cnt = 0;
    done_at = 0;
    for (int i = 1; i <= 25; i++) begin
      @(posedge clk);
      #1;
      if (scan_done) begin
        done_cnt++;
        if (done_at == 0) done_at = i;
      end
    end
    check_eq("restart_done_count", 32'(done_cnt), 32'd1);
    check_eq("restart_done_time", 32'(done_at), 32'd7);
    check_eq("signed_min_val", min_val, 32'h8000_0000);
    check_eq("signed_min_idx", min_idx, 32'd9);

    // Reset during WAIT of a write to word 0 and during a scan.
    bad = 0;
    @(negedge clk);
    mem_write = 1'b1;
    adr = 32'h0;
    wdata = 32'hAA;
    scan_start = 1'b1;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    scan_start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (ready || scan_done) bad++;
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (ready || scan_done) bad++;
    end
    check_eq("abort_no_pulse", 32'(bad), 32'd0);
    check_eq("abort_min_val", min_val, 32'd0);
    do_access(1'b1, 1'b0, 32'h0, 32'h0, rd_v, err_v, lat_v, rdy_v);
    check_eq("abort_rd0", rd_v, 32'd0);
    check_eq("abort_rd0_latency", 32'(lat_v), 32'd2);
    do_access(1'b1, 1'b0, 32'h4, 32'h0, rd_v, err_v, lat_v, rdy_v);
    check_eq("reset_cleared_word1", rd_v, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 256, is the number of 32-bit words.
REQ-002 Parameter LATENCY, default 2, is the number of cycles from request acceptance to the ready pulse; legal range 1..15.
REQ-003 Parameter MIN_BASE, default 0, is the first word index of the min-scan window.
REQ-004 Parameter MIN_COUNT, default 10, is the number of words in the min-scan window; legal range 1..DEPTH-MIN_BASE.
REQ-005 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port adr, input, 32 bits: byte address; word index is adr[31:2].
REQ-008 Port wdata, input, 32 bits: write data.
REQ-009 Port mem_read, input, 1 bit: read request.
REQ-010 Port mem_write, input, 1 bit: write request.
REQ-011 Port rdata, output, 32 bits: read data, valid only while ready is high.
REQ-012 Port ready, output, 1 bit: one-cycle pulse that completes an access.
REQ-013 Port err, output, 1 bit: qualifies ready; the access was rejected.
REQ-014 Port scan_start, input, 1 bit: starts a min scan.
REQ-015 Port min_val, output, 32 bits: signed minimum from the last completed scan.
REQ-016 Port min_idx, output, 32 bits: word index of min_val.
REQ-017 Port scan_done, output, 1 bit: one-cycle pulse when a scan completes.

Function
REQ-018 Access FSM states SHALL be IDLE, WAIT and RESP.
REQ-019 In IDLE, mem_read or mem_write high SHALL accept the request: register adr, wdata and type, load the latency counter, and go to WAIT (or to RESP when LATENCY=1).
REQ-020 ready SHALL rise exactly LATENCY cycles after the acceptance edge, stay high for one cycle in RESP, then return to IDLE.
REQ-021 Requests SHALL be sampled only in IDLE; inputs during WAIT and RESP SHALL be ignored.
REQ-022 Back-to-back accesses SHALL be spaced LATENCY+1 cycles apart.
REQ-023 Reads SHALL drive rdata with the array word at the registered index during RESP; rdata SHALL be 0 when ready is low.
REQ-024 Writes SHALL commit to the array on the RESP edge, and rdata SHALL be 0 for writes.
REQ-025 err SHALL assert with ready, with no array update and rdata=0, in any of these cases: adr[1:0]!=0; word index >= DEPTH; mem_read and mem_write both high at acceptance.
REQ-026 Scan FSM states SHALL be S_IDLE and S_RUN.
REQ-027 A scan_start pulse in S_IDLE SHALL begin a scan; scan_start during S_RUN SHALL be ignored.
REQ-028 The scanner SHALL read one word per cycle, through its own read port, from MIN_BASE to MIN_BASE+MIN_COUNT-1.
REQ-029 The scanner SHALL use a signed 32-bit compare; on a tie it SHALL keep the lower index.
REQ-030 scan_done SHALL pulse MIN_COUNT cycles after the start edge; min_val and min_idx SHALL update on that same edge and hold until the next done.
REQ-031 A write committed during a scan SHALL be visible to the scanner only if it commits before the scanner reads that word.
REQ-032 The access FSM and the scanner SHALL operate concurrently and independently.

Reset
REQ-033 While rst is low: both FSMs idle, latency counter 0, ready=0, err=0, rdata=0, scan_done=0, min_val=0, min_idx=0, and all array words 0.
REQ-034 Reset asserted mid-access or mid-scan SHALL abort it with no ready or done pulse; a pending write SHALL NOT commit.

Structure
REQ-035 Package data_mem_pkg SHALL hold the access and scan state encodings and the defaults for DEPTH and LATENCY.
REQ-036 The scanner SHALL be sub-module min_scanner (word input, index output, start/done), instantiated once.

Verification
REQ-037 Write 0x0000_0010 to adr 0x8, then read 0x8 -> each ready exactly 2 cycles after acceptance; read rdata=0x10; err=0.
REQ-038 Read adr 0x6 -> ready with err=1 and rdata=0; write adr 0x400 (DEPTH=256) -> err=1 and the array is unchanged.
REQ-039 mem_read=mem_write=1 at adr 0x4 -> err=1; word 1 is unchanged.
REQ-040 Words 0..9 = {5,-3,7,-3,9,0,1,2,3,4}, pulse scan_start -> scan_done 10 cycles later; min_val=0xFFFF_FFFD, min_idx=1.
REQ-041 Drop rst during WAIT of a write of 0xAA to adr 0x0 -> no ready pulse; after release, a read of 0x0 returns 0.
REQ-042 Pulse scan_start again while a scan is running -> exactly one scan_done pulse.
